imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Responder end of the core's instruction-fetch handshake (imem_addr/imem_valid -> imem_rdata/imem_ready).
//  Holds a word-organised instruction store and answers each fetch after a configurable number of wait states.
//  Provides a boot/bench load port and flags bad addresses. Sits between the fetch unit and on-chip memory.
// PARAMETERS
//  DEPTH        1024          number of 32-bit words in the store (power of two)
//  WAIT_STATES  2             extra cycles between request capture and response (0..15)
//  BASE_ADDR    32'h00000000  byte address mapped to word 0
// PORTS
//  clock       in   1   single clock, rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  imem_addr   in   32  fetch byte address from fetch unit
//  imem_valid  in   1   fetch request; held high by requester until imem_ready
//  imem_rdata  out  32  instruction word, valid only while imem_ready=1
//  imem_ready  out  1   one-cycle response strobe
//  imem_err    out  1   qualifies imem_ready: misaligned or out-of-range fetch
//  load_en     in   1   store write strobe (boot/bench)
//  load_addr   in   $clog2(DEPTH)  word index for load
//  load_data   in   32  word written when load_en=1
//  fetch_cnt   out  32  count of completed responses (wraps)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, imem_ready=0, imem_err=0, imem_rdata=32'h00000013 (NOP),
//   fetch_cnt=0, wait counter=0. Store contents are not reset.
//  All outputs registered. States: IDLE, WAIT, RESP.
//  IDLE: on edge with imem_valid=1, capture imem_addr into req_addr; if WAIT_STATES=0 -> RESP, else load
//   counter=WAIT_STATES-1 -> WAIT. imem_valid=0 -> stay IDLE.
//  WAIT: counter decrements each cycle; at 0 -> RESP. If imem_valid drops -> IDLE (request abandoned,
//   no response). If imem_addr differs from req_addr -> recapture, reload counter, stay WAIT.
//  Entry into RESP registers imem_rdata, imem_err, imem_ready=1 for exactly one cycle; RESP -> IDLE always.
//  Latency: imem_ready high W+1 cycles after the capture edge (W=WAIT_STATES); with imem_valid held high,
//   one response every W+2 cycles.
//  Address decode: offset = req_addr - BASE_ADDR (32-bit, wraps); word = offset[31:2].
//   err if offset[1:0]!=0 or word>=DEPTH -> imem_rdata=32'h00000013, imem_err=1. Else rdata=mem[word], err=0.
//  imem_rdata/imem_err hold their last value outside RESP; imem_err is meaningful only with imem_ready.
//  Load port: write on edge with load_en=1, independent of state. Load to the word being read on the
//   same edge as RESP entry -> response returns the OLD word (read-before-write).
//  fetch_cnt increments on every RESP cycle, err or not; 32'hFFFFFFFF wraps to 0.
//  Reset mid-WAIT/RESP: immediate return to IDLE, imem_ready drops asynchronously, no response issued.
//  Requester rule: imem_addr must be stable while imem_valid=1 until imem_ready; change is tolerated
//   per WAIT rule above but costs a full restart.
// TESTING
//  1 W=2, load mem[0..3]=0x00500093,0x00A00113,0x002081B3,0x00000013; hold valid, addr 0 -> ready pulses
//    at cycles 3,7,11,15 after reset release with rdata in that order; fetch_cnt=4; err=0.
//  2 W=0, back-to-back valid -> ready every 2nd cycle, each pulse exactly 1 cycle wide.
//  3 addr=0x00000002 -> ready with err=1, rdata=0x00000013; addr=DEPTH*4 -> same; fetch_cnt still increments.
//  4 valid dropped during WAIT -> no ready pulse, state back to IDLE, fetch_cnt unchanged.
//  5 reset_n low during WAIT -> ready=0 immediately, rdata=0x00000013; after release first fetch normal.
//  6 load_en to word 1 (0xDEADBEEF) on RESP-entry edge of fetch 0x4 -> rdata=old value; refetch -> 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-fetch responder: word-organised store answering each fetch after
// WAIT_STATES wait cycles, with a boot load port and bad-address flagging.
module imem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [31:0]              imem_addr,
  input  logic                     imem_valid,
  output logic [31:0]              imem_rdata,
  output logic                     imem_ready,
  output logic                     imem_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              fetch_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [3:0]  WLOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] offset;
  logic        dec_err;
  logic [AW-1:0] word;

  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ready_d     = 1'b0;
    fetch_cnt_d = fetch_cnt_q;

    if (state_q == S_RESP) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (imem_valid) begin
          req_addr_d = imem_addr;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = WLOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!imem_valid) begin
          state_d = S_IDLE;
        end else if (imem_addr != req_addr_q) begin
          req_addr_d = imem_addr;
          cnt_d      = WLOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Decode from req_addr_d so a zero-wait capture responds on the same edge.
    offset  = req_addr_d - BASE_ADDR;
    dec_err = (offset[1:0] != 2'b00) || (|offset[31:AW+2]);
    word    = offset[AW+1:2];

    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      err_d   = dec_err;
      rdata_d = dec_err ? NOP : mem_q[word];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      rdata_q     <= NOP;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_rdata = rdata_q;
  assign imem_ready = ready_q;
  assign imem_err   = err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a 2-wait-state instance and a zero-wait
// instance share all inputs; each task checks one scenario against hand values.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic [31:0] rdata2, cnt2, rdata0, cnt0;
  logic        ready2, err2, ready0, err0;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};

  imem_responder #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(rdata2), .imem_ready(ready2), .imem_err(err2),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .fetch_cnt(cnt2)
  );

  imem_responder #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(rdata0), .imem_ready(ready0), .imem_err(err0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .fetch_cnt(cnt0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    imem_valid = 1'b0;
    load_en    = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err2); end
    checks++; if (rdata2 !== NOP) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", rdata2, NOP); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt2); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", ready0); end
    checks++; if (rdata0 !== NOP) begin errors++; $display("FAIL reset_rdata0 got=%h exp=%h", rdata0, NOP); end
  endtask

  // Sequential fetches of words 0..3, ready after edges 3,7,11,15.
  task automatic test_sequential_fetch();
    do_reset();
    imem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_addr = 32'(4 * k);
      for (int n = 1; n <= 4; n++) begin
        tick();
        if (n == 3) begin
          checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL seq_ready k=%0d got=%b exp=1", k, ready2); end
          checks++; if (rdata2 !== prog[k]) begin errors++; $display("FAIL seq_rdata k=%0d got=%h exp=%h", k, rdata2, prog[k]); end
          checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL seq_err k=%0d got=%b exp=0", k, err2); end
        end else begin
          checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL seq_idle k=%0d n=%0d got=%b exp=0", k, n, ready2); end
        end
      end
    end
    imem_valid = 1'b0;
    checks++; if (cnt2 !== 32'd4) begin errors++; $display("FAIL seq_cnt got=%0d exp=4", cnt2); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem_addr  = 32'h4;
    imem_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (ready0 !== 1'((n % 2) == 1)) begin
        errors++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, ready0, 1'((n % 2) == 1));
      end
      if ((n % 2) == 1) begin
        checks++; if (rdata0 !== 32'h00A0_0113) begin errors++; $display("FAIL b2b_rdata n=%0d got=%h exp=00a00113", n, rdata0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL b2b_err n=%0d got=%b exp=0", n, err0); end
      end
    end
    imem_valid = 1'b0;
    checks++; if (cnt0 !== 32'd4) begin errors++; $display("FAIL b2b_cnt got=%0d exp=4", cnt0); end
  endtask

  task automatic test_bad_address();
    logic [31:0] addrs [3] = '{32'h0, 32'h2, 32'h1000};
    logic [31:0] exp_rd [3] = '{32'h0050_0093, NOP, NOP};
    logic        exp_err [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    imem_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_addr = addrs[k];
      for (int n = 1; n <= 4; n++) begin
        tick();
        if (n == 3) begin
          checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL bad_ready k=%0d got=%b exp=1", k, ready2); end
          checks++; if (err2 !== exp_err[k]) begin errors++; $display("FAIL bad_err k=%0d got=%b exp=%b", k, err2, exp_err[k]); end
          checks++; if (rdata2 !== exp_rd[k]) begin errors++; $display("FAIL bad_rdata k=%0d got=%h exp=%h", k, rdata2, exp_rd[k]); end
        end
      end
    end
    imem_valid = 1'b0;
    checks++; if (cnt2 !== 32'd3) begin errors++; $display("FAIL bad_cnt got=%0d exp=3", cnt2); end
  endtask

  task automatic test_abandon();
    do_reset();
    imem_addr  = 32'h0;
    imem_valid = 1'b1;
    tick();
    tick();
    imem_valid = 1'b0;
    for (int n = 3; n <= 6; n++) begin
      tick();
      checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL abandon_ready n=%0d got=%b exp=0", n, ready2); end
    end
    checks++; if (cnt2 !== 32'd0) begin errors++; $display("FAIL abandon_cnt got=%0d exp=0", cnt2); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    imem_addr  = 32'h8;
    imem_valid = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL rstwait_ready got=%b exp=0", ready2); end
    checks++; if (rdata2 !== NOP) begin errors++; $display("FAIL rstwait_rdata got=%h exp=%h", rdata2, NOP); end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL rstrel_early got=%b exp=0", ready2); end
    tick();
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rstrel_ready got=%b exp=1", ready2); end
    checks++; if (rdata2 !== 32'h0020_81B3) begin errors++; $display("FAIL rstrel_rdata got=%h exp=002081b3", rdata2); end
    reset_n = 1'b0;
    #1;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL rstresp_ready got=%b exp=0", ready2); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $display("FAIL rstresp_cnt got=%0d exp=0", cnt2); end
    imem_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_load_collision();
    do_reset();
    imem_addr  = 32'h4;
    imem_valid = 1'b1;
    tick();
    tick();
    load_en   = 1'b1;
    load_addr = 10'd1;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rbw_ready got=%b exp=1", ready2); end
    checks++; if (rdata2 !== 32'h00A0_0113) begin errors++; $display("FAIL rbw_old got=%h exp=00a00113", rdata2); end
    for (int n = 4; n <= 7; n++) tick();
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rbw_ready2 got=%b exp=1", ready2); end
    checks++; if (rdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_new got=%h exp=deadbeef", rdata2); end
    imem_valid = 1'b0;
    tick();
    checks++; if (cnt2 !== 32'd2) begin errors++; $display("FAIL rbw_cnt got=%0d exp=2", cnt2); end
  endtask

  initial begin
    reset_n    = 1'b0;
    imem_addr  = '0;
    imem_valid = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    test_reset();
    test_sequential_fetch();
    test_back_to_back();
    test_bad_address();
    test_abandon();
    test_reset_midflight();
    test_load_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
